hazard_forward_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage 16-bit core (16 GPRs, 4-bit register IDs, R0 hardwired to zero).
- Sits beside the EX/MEM forwarding muxes and drives their select lines.
- Tracks destination/source info for the instructions in EX, MEM and WB in its own shadow pipeline registers.
- Generates the load-use stall and inserts bubbles on stall or branch flush.

---
 rtl/hazard_forward_ctrl_pkg.sv | 27 ++
 rtl/hazard_forward_ctrl_slot_reg.sv | 21 ++
 rtl/hazard_forward_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: shadow-slot layout,
// the all-zero bubble constant and the "writer" predicate.
package hazard_forward_ctrl_pkg;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             uses_rs;
    logic             uses_rt;
    logic [REG_W-1:0] dst;
    logic             wen;
    logic             is_load;
    logic             is_store;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  // R0 writes are architecturally discarded, so they never count as producers.
  function automatic logic is_writer(input slot_t s);
    return s.valid && s.wen && (s.dst != ZERO_REG);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_slot_reg.sv
// One shadow pipeline slot: sync reset and bubble insertion override data load.
module hazard_slot_reg
  import hazard_forward_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load_bubble,
  input  logic  load_data,
  input  slot_t d,
  output slot_t q
);

  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      q <= BUBBLE;
    end else if (load_data) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall and EX/MEM forwarding-select generation from an E/M/W shadow
// pipeline. Optional saturating event counters under `HAZARD_STATS_EN.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_W              = 4,
  parameter int NUM_STAGES_TRACKED = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_uses_rs,
  input  logic             d_uses_rt,
  input  logic [REG_W-1:0] d_dst,
  input  logic             d_wen,
  input  logic             d_is_load,
  input  logic             d_is_store,
  input  logic             d_valid,
  input  logic             flush,
  output logic [1:0]       ex_ex_forwarding,
  output logic [1:0]       ex_mem_forwarding,
  output logic             mem_mem_forwarding,
  output logic             stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]      stat_stall_cycles,
  output logic [15:0]      stat_fwd_ex,
  output logic [15:0]      stat_fwd_mem
`endif
);

  slot_t d_slot;
  slot_t slot_q [NUM_STAGES_TRACKED];
  slot_t e, m, w;
  logic  e_bubble;

  always_comb begin
    d_slot          = BUBBLE;
    d_slot.valid    = d_valid;
    d_slot.rs       = d_rs;
    d_slot.rt       = d_rt;
    d_slot.uses_rs  = d_uses_rs;
    d_slot.uses_rt  = d_uses_rt;
    d_slot.dst      = d_dst;
    d_slot.wen      = d_wen;
    d_slot.is_load  = d_is_load;
    d_slot.is_store = d_is_store;
  end

  // Stall and flush both squash the Decode instruction into a single bubble.
  assign e_bubble = stall || flush || !d_valid;

  // Shadow pipeline: slot 0 = EX, 1 = MEM, 2 = WB
  for (genvar i = 0; i < NUM_STAGES_TRACKED; i++) begin : g_slot
    if (i == 0) begin : g_first
      hazard_slot_reg u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_bubble (e_bubble),
        .load_data   (1'b1),
        .d           (d_slot),
        .q           (slot_q[i])
      );
    end else begin : g_rest
      hazard_slot_reg u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_bubble (1'b0),
        .load_data   (1'b1),
        .d           (slot_q[i-1]),
        .q           (slot_q[i])
      );
    end
  end

  assign e = slot_q[0];
  assign m = slot_q[1];
  assign w = slot_q[2];

  // Hazard decode: combinational from the slots and Decode inputs
  always_comb begin
    ex_ex_forwarding   = 2'b00;
    ex_mem_forwarding  = 2'b00;
    mem_mem_forwarding = 1'b0;
    stall              = 1'b0;

    // A load in MEM has no result yet; its consumer was already stalled.
    ex_ex_forwarding[0] = e.uses_rs && is_writer(m) && (m.dst == e.rs) && !m.is_load;
    ex_ex_forwarding[1] = e.uses_rt && is_writer(m) && (m.dst == e.rt) && !m.is_load;

    ex_mem_forwarding[0] = e.uses_rs && is_writer(w) && (w.dst == e.rs) && !ex_ex_forwarding[0];
    ex_mem_forwarding[1] = e.uses_rt && is_writer(w) && (w.dst == e.rt) && !ex_ex_forwarding[1];

    mem_mem_forwarding = m.valid && m.is_store && is_writer(w) && (w.dst == m.rt);

    // SW store data behind LW is picked up later by MEM->MEM forwarding.
    stall = d_valid && is_writer(e) && e.is_load &&
            ((d_uses_rs && (d_rs == e.dst)) ||
             (d_uses_rt && (d_rt == e.dst) && !d_is_store));
  end

  logic unused_fields;
  assign unused_fields = ^{e.is_store, m.rs, m.uses_rs, m.uses_rt,
                           w.rs, w.rt, w.uses_rs, w.uses_rt, w.is_load, w.is_store};

`ifdef HAZARD_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    return (en && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_fwd_ex       <= '0;
      stat_fwd_mem      <= '0;
    end else begin
      stat_stall_cycles <= sat_inc(stat_stall_cycles, stall);
      stat_fwd_ex       <= sat_inc(stat_fwd_ex, |ex_ex_forwarding);
      stat_fwd_mem      <= sat_inc(stat_fwd_mem, (|ex_mem_forwarding) || mem_mem_forwarding);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed program fragments plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_hazard_forward_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d_rs, d_rt, d_dst;
  logic       d_uses_rs, d_uses_rt, d_wen, d_is_load, d_is_store, d_valid, flush;
  logic [1:0] ex_ex_forwarding, ex_mem_forwarding;
  logic       mem_mem_forwarding, stall;
`ifdef HAZARD_STATS_EN
  logic [15:0] stat_stall_cycles, stat_fwd_ex, stat_fwd_mem;
`endif

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk                (clk),
    .rst                (rst),
    .d_rs               (d_rs),
    .d_rt               (d_rt),
    .d_uses_rs          (d_uses_rs),
    .d_uses_rt          (d_uses_rt),
    .d_dst              (d_dst),
    .d_wen              (d_wen),
    .d_is_load          (d_is_load),
    .d_is_store         (d_is_store),
    .d_valid            (d_valid),
    .flush              (flush),
    .ex_ex_forwarding   (ex_ex_forwarding),
    .ex_mem_forwarding  (ex_mem_forwarding),
    .mem_mem_forwarding (mem_mem_forwarding),
    .stall              (stall)
`ifdef HAZARD_STATS_EN
    ,
    .stat_stall_cycles  (stat_stall_cycles),
    .stat_fwd_ex        (stat_fwd_ex),
    .stat_fwd_mem       (stat_fwd_mem)
`endif
  );

  typedef struct {
    bit       valid;
    bit [3:0] rs;
    bit [3:0] rt;
    bit       urs;
    bit       urt;
    bit [3:0] dst;
    bit       wen;
    bit       ld;
    bit       st;
  } ins_t;

  ins_t pipe [3];              // instructions currently in EX, MEM, WB
  int   checks = 0;
  int   errors = 0;
  int   cnt_stall = 0, cnt_ex = 0, cnt_mem = 0;
  bit   last_exp_stall = 0;
  logic [1:0] obs_exex, obs_exmem;
  logic       obs_mm, obs_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t nop();
    ins_t i = '{default: 0};
    return i;
  endfunction

  function automatic ins_t alu(input bit [3:0] dst, input bit [3:0] rs, input bit [3:0] rt);
    ins_t i = '{default: 0};
    i.valid = 1; i.dst = dst; i.rs = rs; i.rt = rt; i.urs = 1; i.urt = 1; i.wen = 1;
    return i;
  endfunction

  function automatic ins_t lw(input bit [3:0] dst, input bit [3:0] base);
    ins_t i = '{default: 0};
    i.valid = 1; i.dst = dst; i.rs = base; i.urs = 1; i.wen = 1; i.ld = 1;
    return i;
  endfunction

  function automatic ins_t sw(input bit [3:0] src, input bit [3:0] base);
    ins_t i = '{default: 0};
    i.valid = 1; i.rs = base; i.rt = src; i.urs = 1; i.urt = 1; i.st = 1;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    case ($urandom_range(0, 5))
      0:       begin
                 i = alu(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
                 i.valid = 0;   // junk fields behind an invalid Decode slot
               end
      1, 2:    i = alu(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      3:       i = lw(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      default: i = sw(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    endcase
    return i;
  endfunction

  // True when instruction p will write architectural register r.
  function automatic bit produces(input ins_t p, input bit [3:0] r);
    return p.valid && p.wen && (p.dst != 0) && (p.dst == r);
  endfunction

  // Where an EX operand must come from: 0 register file, 1 MEM result, 2 WB data.
  function automatic int operand_src(input bit used, input bit [3:0] r);
    if (!pipe[0].valid || !used) return 0;
    if (produces(pipe[1], r) && !pipe[1].ld) return 1;
    if (produces(pipe[2], r)) return 2;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Present one Decode slot for one cycle, check outputs, then advance the model.
  task automatic cycle(input ins_t d, input bit fl, input bit r);
    int  s_rs, s_rt;
    bit  e_st, e_mm;
    bit [1:0] e_exex, e_exmem;
    d_valid = d.valid; d_rs = d.rs; d_rt = d.rt; d_uses_rs = d.urs; d_uses_rt = d.urt;
    d_dst = d.dst; d_wen = d.wen; d_is_load = d.ld; d_is_store = d.st;
    flush = fl; rst = r;
    #4;
    s_rs    = operand_src(pipe[0].urs, pipe[0].rs);
    s_rt    = operand_src(pipe[0].urt, pipe[0].rt);
    e_exex  = {s_rt == 1, s_rs == 1};
    e_exmem = {s_rt == 2, s_rs == 2};
    e_mm    = pipe[1].valid && pipe[1].st && produces(pipe[2], pipe[1].rt);
    e_st    = d.valid && pipe[0].ld &&
              ((d.urs && produces(pipe[0], d.rs)) || (d.urt && !d.st && produces(pipe[0], d.rt)));
    obs_exex = ex_ex_forwarding; obs_exmem = ex_mem_forwarding;
    obs_mm = mem_mem_forwarding; obs_stall = stall;
    check("ex_ex_forwarding", 32'(ex_ex_forwarding), 32'(e_exex));
    check("ex_mem_forwarding", 32'(ex_mem_forwarding), 32'(e_exmem));
    check("mem_mem_forwarding", 32'(mem_mem_forwarding), 32'(e_mm));
    check("stall", 32'(stall), 32'(e_st));
`ifdef HAZARD_STATS_EN
    check("stat_stall_cycles", 32'(stat_stall_cycles), cnt_stall);
    check("stat_fwd_ex", 32'(stat_fwd_ex), cnt_ex);
    check("stat_fwd_mem", 32'(stat_fwd_mem), cnt_mem);
`endif
    last_exp_stall = e_st;
    @(posedge clk);
    if (r) begin
      pipe[0] = nop(); pipe[1] = nop(); pipe[2] = nop();
      cnt_stall = 0; cnt_ex = 0; cnt_mem = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (e_st || fl || !d.valid) ? nop() : d;
      if (e_st) cnt_stall = sat(cnt_stall);
      if (e_exex != 0) cnt_ex = sat(cnt_ex);
      if (e_exmem != 0 || e_mm) cnt_mem = sat(cnt_mem);
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) cycle(nop(), 0, 0);
  endtask

  initial begin
    bit   seen;
    bit   fl;
    ins_t held;
    bit   have_held;

    pipe[0] = nop(); pipe[1] = nop(); pipe[2] = nop();
    d_valid = 0; d_rs = 0; d_rt = 0; d_uses_rs = 0; d_uses_rt = 0; d_dst = 0;
    d_wen = 0; d_is_load = 0; d_is_store = 0; flush = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    cycle(nop(), 0, 0);
    check("reset_outputs", 32'({obs_exex, obs_exmem, obs_mm, obs_stall}), 0);

    // ADD R1,R2,R3 ; ADD R4,R1,R5
    seen = 0;
    cycle(alu(1, 2, 3), 0, 0); seen |= obs_stall;
    cycle(alu(4, 1, 5), 0, 0); seen |= obs_stall;
    cycle(nop(), 0, 0);        seen |= obs_stall;
    check("p1_ex_ex", 32'(obs_exex), 32'b01);
    check("p1_ex_mem", 32'(obs_exmem), 32'b00);
    drain();
    check("p1_no_stall", 32'(seen), 0);

    // ADD R1,.. ; NOP ; SUB R6,R7,R1
    cycle(alu(1, 2, 3), 0, 0);
    cycle(nop(), 0, 0);
    cycle(alu(6, 7, 1), 0, 0);
    cycle(nop(), 0, 0);
    check("p2_ex_mem", 32'(obs_exmem), 32'b10);
    check("p2_ex_ex", 32'(obs_exex), 32'b00);
    drain();

    // LW R2,0(R3) ; ADD R4,R2,R2 (held in Decode for the stall cycle)
    cycle(lw(2, 3), 0, 0);
    cycle(alu(4, 2, 2), 0, 0);
    check("p3_stall", 32'(obs_stall), 1);
    cycle(alu(4, 2, 2), 0, 0);
    check("p3_bubble", 32'({obs_exex, obs_exmem, obs_mm, obs_stall}), 0);
    cycle(nop(), 0, 0);
    check("p3_ex_mem", 32'(obs_exmem), 32'b11);
    drain();

    // LW R2,0(R3) ; SW R2,0(R5)
    seen = 0;
    cycle(lw(2, 3), 0, 0);
    cycle(sw(2, 5), 0, 0); seen |= obs_stall;
    cycle(nop(), 0, 0);    seen |= obs_stall;
    cycle(nop(), 0, 0);
    check("p4_no_stall", 32'(seen), 0);
    check("p4_mem_mem", 32'(obs_mm), 1);
    drain();

    // R0 destination never forwards; flushed producer never appears
    seen = 0;
    cycle(alu(0, 1, 1), 0, 0); seen |= |{obs_exex, obs_exmem, obs_mm, obs_stall};
    cycle(alu(4, 0, 0), 0, 0); seen |= |{obs_exex, obs_exmem, obs_mm, obs_stall};
    for (int k = 0; k < 3; k++) begin
      cycle(nop(), 0, 0); seen |= |{obs_exex, obs_exmem, obs_mm, obs_stall};
    end
    check("p5_r0_quiet", 32'(seen), 0);
    seen = 0;
    cycle(alu(1, 2, 3), 1, 0); seen |= |{obs_exex, obs_exmem, obs_mm, obs_stall};
    cycle(alu(4, 1, 1), 0, 0); seen |= |{obs_exex, obs_exmem, obs_mm, obs_stall};
    for (int k = 0; k < 3; k++) begin
      cycle(nop(), 0, 0); seen |= |{obs_exex, obs_exmem, obs_mm, obs_stall};
    end
    check("p5_flush_quiet", 32'(seen), 0);

    // Reset while a load-use hazard is pending
    cycle(lw(2, 3), 0, 0);
    cycle(alu(4, 2, 2), 0, 1);
    check("p6_stall_pending", 32'(obs_stall), 1);
    cycle(alu(4, 2, 2), 0, 0);
    check("p6_after_reset", 32'({obs_exex, obs_exmem, obs_mm, obs_stall}), 0);
    drain();

    // Randomized streams; a stalled Decode instruction is re-presented
    have_held = 0;
    held = nop();
    for (int n = 0; n < 4000; n++) begin
      ins_t d;
      fl = ($urandom_range(0, 9) == 0);
      d = have_held ? held : rand_ins();
      cycle(d, fl, $urandom_range(0, 299) == 0);
      have_held = last_exp_stall && !fl;
      held = d;
    end

`ifdef HAZARD_STATS_EN
    cycle(nop(), 0, 1);
    cycle(nop(), 0, 0);
    check("stats_reset", 32'({stat_stall_cycles, stat_fwd_ex}), 0);
    check("stats_reset_mem", 32'(stat_fwd_mem), 0);
    for (int n = 0; n < 65600; n++) cycle(alu(1, 1, 1), 0, 0);
    check("stat_fwd_ex_sat", 32'(stat_fwd_ex), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
